fpu_addsub_param: RTL

FPU_ADDSUB_PARAM -- requirements
Module: fpu_addsub_param

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_addsub_param.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and default geometry for the multi-cycle floating-point adder/subtractor.
package fpu_pkg;

    localparam int DEF_EXP_W = 6;
    localparam int DEF_MAN_W = 25;

    typedef enum logic [3:0] {
        ST_NONE      = 4'b0000,
        ST_EXACT     = 4'b0001,
        ST_INEXACT   = 4'b0010,
        ST_OVERFLOW  = 4'b0100,
        ST_UNDERFLOW = 4'b1000
    } fpu_status_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } fpu_state_t;

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
    parameter int WIDTH = 29,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Later (higher) set bits override earlier ones, so the MSB-most one wins.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point add/subtract: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
// Define FPU_RNE_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module fpu_addsub_param
    import fpu_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                   clock100KHz,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   op_A_in,
    input  logic [EXP_W+MAN_W:0]   op_B_in,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   data_out,
    output logic [3:0]             status_out
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int EXT_W = SIG_W + 3;
    localparam int SUM_W = EXT_W + 1;
    localparam int LZC_W = $clog2(EXT_W + 1);
    localparam int EW    = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 2;

    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << EXP_W) - 1);

    fpu_state_t         state_reg;
    fpu_status_t        status_reg;
    logic               busy_reg, done_reg;
    logic [W-1:0]       data_reg;
    logic [W-1:0]       a_reg, b_reg;
    logic [EXT_W-1:0]   big_ext_reg, small_ext_reg;
    logic               sign_reg, sub_reg;
    logic signed [EW-1:0] exp_reg;
    logic [SUM_W-1:0]   sum_reg;
    logic [EXT_W-1:0]   norm_reg;
    logic               zero_reg, inexact_reg;
    logic [MAN_W-1:0]   mant_reg;

    logic               a_ge_b;
    logic [W-1:0]       big_op, small_op;
    logic [EXP_W-1:0]   big_exp, small_exp, exp_diff;
    logic [SIG_W-1:0]   big_sig, small_sig;
    logic [EXT_W-1:0]   small_ext, lost_mask, align_small;
    logic [SUM_W-1:0]   sum_next;
    logic [LZC_W-1:0]   lz_count;
    logic [EXT_W-1:0]   norm_next;
    logic signed [EW-1:0] norm_exp_next, round_exp_next;
    logic               round_up;
    logic [SIG_W:0]     rounded;
    logic [MAN_W-1:0]   mant_next;

    // Operand ordering by magnitude: exponent dominates, mantissa breaks ties.
    always_comb begin
        a_ge_b    = a_reg[W-2:0] >= b_reg[W-2:0];
        big_op    = a_ge_b ? a_reg : b_reg;
        small_op  = a_ge_b ? b_reg : a_reg;
        big_exp   = big_op[W-2:MAN_W];
        small_exp = small_op[W-2:MAN_W];
        big_sig   = (big_exp == '0) ? '0 : {1'b1, big_op[MAN_W-1:0]};
        small_sig = (small_exp == '0) ? '0 : {1'b1, small_op[MAN_W-1:0]};
        exp_diff  = big_exp - small_exp;
        small_ext = {small_sig, 3'b000};
        lost_mask = ~({EXT_W{1'b1}} << exp_diff);
        if (int'(exp_diff) > MAN_W + 2)
            align_small = {{(EXT_W-1){1'b0}}, |small_sig};
        else
            align_small = (small_ext >> exp_diff)
                        | {{(EXT_W-1){1'b0}}, |(small_ext & lost_mask)};
    end

    always_comb begin
        if (sub_reg)
            sum_next = {1'b0, big_ext_reg} - {1'b0, small_ext_reg};
        else
            sum_next = {1'b0, big_ext_reg} + {1'b0, small_ext_reg};
    end

    fpu_lzc #(
        .WIDTH (EXT_W),
        .CNT_W (LZC_W)
    ) u_lzc (
        .value (sum_reg[EXT_W-1:0]),
        .count (lz_count)
    );

    always_comb begin
        if (sum_reg[SUM_W-1]) begin
            norm_next     = {sum_reg[SUM_W-1:2], sum_reg[1] | sum_reg[0]};
            norm_exp_next = exp_reg + EXP_ONE;
        end else begin
            norm_next     = sum_reg[EXT_W-1:0] << lz_count;
            norm_exp_next = exp_reg - $signed({{(EW-LZC_W){1'b0}}, lz_count});
        end
    end

    // Low three bits of norm_reg are guard, round and sticky; bit 3 is the result LSB.
    always_comb begin
`ifdef FPU_RNE_ROUND_EN
        round_up = norm_reg[2] & (norm_reg[1] | norm_reg[0] | norm_reg[3]);
`else
        round_up = 1'b0;
`endif
        rounded = {1'b0, norm_reg[EXT_W-1:3]} + (SIG_W+1)'(round_up);
        if (rounded[SIG_W]) begin
            mant_next      = rounded[MAN_W:1];
            round_exp_next = exp_reg + EXP_ONE;
        end else begin
            mant_next      = rounded[MAN_W-1:0];
            round_exp_next = exp_reg;
        end
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            status_reg    <= ST_NONE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            data_reg      <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            big_ext_reg   <= '0;
            small_ext_reg <= '0;
            sign_reg      <= 1'b0;
            sub_reg       <= 1'b0;
            exp_reg       <= '0;
            sum_reg       <= '0;
            norm_reg      <= '0;
            zero_reg      <= 1'b0;
            inexact_reg   <= 1'b0;
            mant_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // busy is still high during the done cycle, which blocks acceptance there.
                    if (busy_reg) begin
                        busy_reg <= 1'b0;
                    end else if (start) begin
                        a_reg     <= op_A_in;
                        b_reg     <= {op_B_in[W-1] ^ op_sub, op_B_in[W-2:0]};
                        busy_reg  <= 1'b1;
                        state_reg <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    big_ext_reg   <= {big_sig, 3'b000};
                    small_ext_reg <= align_small;
                    sign_reg      <= big_op[W-1];
                    sub_reg       <= big_op[W-1] ^ small_op[W-1];
                    exp_reg       <= $signed({{(EW-EXP_W){1'b0}}, big_exp});
                    state_reg     <= S_ADD;
                end
                S_ADD: begin
                    sum_reg <= sum_next;
                    if (sum_next == '0) sign_reg <= 1'b0;
                    state_reg <= S_NORM;
                end
                S_NORM: begin
                    norm_reg  <= norm_next;
                    exp_reg   <= norm_exp_next;
                    zero_reg  <= (sum_reg == '0);
                    state_reg <= S_ROUND;
                end
                S_ROUND: begin
                    mant_reg    <= mant_next;
                    exp_reg     <= round_exp_next;
                    inexact_reg <= |norm_reg[2:0];
                    state_reg   <= S_DONE;
                end
                S_DONE: begin
                    if (zero_reg) begin
                        data_reg   <= '0;
                        status_reg <= ST_EXACT;
                    end else if (exp_reg >= EXP_TOP) begin
                        data_reg   <= '0;
                        status_reg <= ST_OVERFLOW;
                    end else if (exp_reg <= EXP_ZERO) begin
                        data_reg   <= '0;
                        status_reg <= ST_UNDERFLOW;
                    end else begin
                        data_reg   <= {sign_reg, exp_reg[EXP_W-1:0], mant_reg};
                        status_reg <= inexact_reg ? ST_INEXACT : ST_EXACT;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign data_out   = data_reg;
    assign status_out = status_reg;

endmodule
